// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: fetch and data ports share one memory with a fixed read latency.
// Data wins by default; a saturating counter hands the slot to fetch after STARVE_MAX back-to-back data grants.
module mem_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IReq,
    input  logic [31:0] IAddr,
    output logic        IGnt,
    output logic        IValid,
    output logic [31:0] IRData,
    input  logic        DReq,
    input  logic        DWe,
    input  logic [31:0] DAddr,
    input  logic [31:0] DWData,
    input  logic [1:0]  DSize,
    input  logic        DSign,
    output logic        DGnt,
    output logic        DValid,
    output logic [31:0] DRData,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic        MemRe,
    output logic        MemWe,
    output logic [1:0]  MemSize,
    output logic        MemSign,
    input  logic [31:0] MemRData,
    output logic        Busy
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
    localparam logic [LW-1:0] LAT_LAST   = LW'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [LW-1:0] latCnt;
    logic [SW-1:0] starveCnt;
    logic          ownerD;
    logic          ownerStore;
    logic          canIssue;
    logic          grantI;
    logic          grantD;

    // Grants are gated by RST so they drop the instant reset asserts.
    assign canIssue = RST && (state != WAIT);
    assign grantI   = canIssue && IReq && (!DReq || (starveCnt == STARVE_TOP));
    assign grantD   = canIssue && DReq && !grantI;

    always_comb begin
        IGnt     = grantI;
        DGnt     = grantD;
        MemRe    = grantI || (grantD && !DWe);
        MemWe    = grantD && DWe;
        MemAddr  = 32'd0;
        MemWData = 32'd0;
        MemSize  = 2'd2;
        MemSign  = 1'b0;
        if (grantD) begin
            MemAddr = DAddr;
            MemSize = DSize;
            MemSign = DSign;
            if (DWe) begin
                MemWData = DWData;
            end
        end else if (grantI) begin
            MemAddr = IAddr;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            latCnt     <= '0;
            starveCnt  <= '0;
            ownerD     <= 1'b0;
            ownerStore <= 1'b0;
            IRData     <= 32'd0;
            DRData     <= 32'd0;
            IValid     <= 1'b0;
            DValid     <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            IValid <= 1'b0;
            DValid <= 1'b0;
            case (state)
                WAIT: begin
                    if (latCnt == LAT_LAST) begin
                        state  <= RESP;
                        Busy   <= 1'b0;
                        latCnt <= '0;
                        IValid <= !ownerD;
                        DValid <= ownerD;
                        if (!ownerD) begin
                            IRData <= MemRData;
                        end else if (!ownerStore) begin
                            DRData <= MemRData;
                        end
                    end else begin
                        latCnt <= latCnt + 1'b1;
                    end
                end
                default: begin
                    // IDLE and RESP behave alike: both may accept a new issue.
                    if (grantI || grantD) begin
                        state      <= WAIT;
                        Busy       <= 1'b1;
                        latCnt     <= '0;
                        ownerD     <= grantD;
                        ownerStore <= grantD && DWe;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase

            if (grantI) begin
                starveCnt <= '0;
            end else if (grantD) begin
                if (!IReq) begin
                    starveCnt <= '0;
                end else if (starveCnt != STARVE_TOP) begin
                    starveCnt <= starveCnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus randomized traffic, each cycle checked against a transaction-level model.
module tb_mem_arbiter;

    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        IReq = 1'b0;
    logic [31:0] IAddr = 32'd0;
    logic        IGnt, IValid;
    logic [31:0] IRData;
    logic        DReq = 1'b0;
    logic        DWe = 1'b0;
    logic [31:0] DAddr = 32'd0;
    logic [31:0] DWData = 32'd0;
    logic [1:0]  DSize = 2'd2;
    logic        DSign = 1'b0;
    logic        DGnt, DValid;
    logic [31:0] DRData;
    logic [31:0] MemAddr, MemWData;
    logic        MemRe, MemWe;
    logic [1:0]  MemSize;
    logic        MemSign;
    logic [31:0] MemRData = 32'd0;
    logic        Busy;

    mem_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .CLK(CLK), .RST(RST),
        .IReq(IReq), .IAddr(IAddr), .IGnt(IGnt), .IValid(IValid), .IRData(IRData),
        .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWData(DWData), .DSize(DSize), .DSign(DSign),
        .DGnt(DGnt), .DValid(DValid), .DRData(DRData),
        .MemAddr(MemAddr), .MemWData(MemWData), .MemRe(MemRe), .MemWe(MemWe),
        .MemSize(MemSize), .MemSign(MemSign), .MemRData(MemRData), .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    int testCnt = 0;
    int failCnt = 0;

    // Memory content: written by observed stores, otherwise an address hash.
    logic [31:0] memArr [logic [31:0]];
    int          rdDue [$];
    logic [31:0] rdAddr [$];

    // Reference model: one outstanding transaction, identified by its issue cycle.
    int          cyc = 0;
    bit          mActive = 1'b0;
    int          mIssueCyc = 0;
    bit          mOwnerD = 1'b0;
    bit          mStore = 1'b0;
    logic [31:0] mData = 32'd0;
    logic [31:0] expIR = 32'd0;
    logic [31:0] expDR = 32'd0;
    int          starve = 0;
    bit          expIG, expDG;

    logic        obsIGnt, obsDGnt, obsIValid, obsDValid, obsMemRe, obsMemWe;
    logic [31:0] obsIRData, obsDRData, obsMemAddr, obsMemWData;
    logic [1:0]  obsMemSize;

    function automatic logic [31:0] memRd(input logic [31:0] a);
        if (memArr.exists(a)) return memArr[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rstChecks(input string pfx);
        chk({pfx, "_IGnt"}, 32'(IGnt), 32'd0);
        chk({pfx, "_DGnt"}, 32'(DGnt), 32'd0);
        chk({pfx, "_IValid"}, 32'(IValid), 32'd0);
        chk({pfx, "_DValid"}, 32'(DValid), 32'd0);
        chk({pfx, "_MemRe"}, 32'(MemRe), 32'd0);
        chk({pfx, "_MemWe"}, 32'(MemWe), 32'd0);
        chk({pfx, "_Busy"}, 32'(Busy), 32'd0);
        chk({pfx, "_IRData"}, IRData, 32'd0);
        chk({pfx, "_DRData"}, DRData, 32'd0);
    endtask

    task automatic modelEdge();
        int since;
        since = cyc - mIssueCyc;
        if (!RST) begin
            mActive = 1'b0;
            starve  = 0;
            expIR   = 32'd0;
            expDR   = 32'd0;
        end else begin
            if (mActive && since == MEM_LAT && !mStore) begin
                if (mOwnerD) expDR = mData;
                else expIR = mData;
            end
            if (expIG || expDG) begin
                mActive   = 1'b1;
                mIssueCyc = cyc;
                mOwnerD   = expDG;
                mStore    = expDG && DWe;
                mData     = memRd(expDG ? DAddr : IAddr);
                if (expIG) starve = 0;
                else if (IReq) starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;
                else starve = 0;
                $display("[TB] cyc=%0d grant=%s we=%0d addr=%h", cyc, expDG ? "D" : "I",
                         mStore, expDG ? DAddr : IAddr);
            end
        end
        cyc++;
    endtask

    // One clock: check at negedge, act as memory, advance model after the edge.
    task automatic tick();
        int  since;
        bit  canIssue;
        since    = cyc - mIssueCyc;
        @(negedge CLK);
        canIssue = RST && (!mActive || since >= MEM_LAT + 1);
        expIG    = canIssue && IReq && (!DReq || starve == STARVE_MAX);
        expDG    = canIssue && DReq && !expIG;
        chk("IGnt", 32'(IGnt), 32'(expIG));
        chk("DGnt", 32'(DGnt), 32'(expDG));
        chk("MemRe", 32'(MemRe), 32'(expIG || (expDG && !DWe)));
        chk("MemWe", 32'(MemWe), 32'(expDG && DWe));
        chk("MemWData", MemWData, (expDG && DWe) ? DWData : 32'd0);
        if (expIG || expDG) chk("MemAddr", MemAddr, expDG ? DAddr : IAddr);
        if (expDG) begin
            chk("MemSize", 32'(MemSize), 32'(DSize));
            chk("MemSign", 32'(MemSign), 32'(DSign));
        end
        chk("Busy", 32'(Busy), 32'(mActive && since >= 1 && since <= MEM_LAT));
        chk("IValid", 32'(IValid), 32'(mActive && since == MEM_LAT + 1 && !mOwnerD));
        chk("DValid", 32'(DValid), 32'(mActive && since == MEM_LAT + 1 && mOwnerD));
        chk("IRData", IRData, expIR);
        chk("DRData", DRData, expDR);
        obsIGnt = IGnt;   obsDGnt = DGnt;   obsIValid = IValid; obsDValid = DValid;
        obsMemRe = MemRe; obsMemWe = MemWe; obsIRData = IRData; obsDRData = DRData;
        obsMemAddr = MemAddr; obsMemWData = MemWData; obsMemSize = MemSize;
        if (MemRe) begin
            rdDue.push_back(cyc + MEM_LAT);
            rdAddr.push_back(MemAddr);
        end
        if (MemWe) memArr[MemAddr] = MemWData;
        @(posedge CLK);
        #1;
        modelEdge();
        MemRData = {16'hBAD0, 16'(cyc)};
        while (rdDue.size() > 0 && rdDue[0] < cyc) begin
            void'(rdDue.pop_front());
            void'(rdAddr.pop_front());
        end
        if (rdDue.size() > 0 && rdDue[0] == cyc) begin
            MemRData = memRd(rdAddr[0]);
            void'(rdDue.pop_front());
            void'(rdAddr.pop_front());
        end
    endtask

    task automatic idle(input int n);
        IReq = 1'b0;
        DReq = 1'b0;
        DWe  = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        string seq;
        int    seenIG, seenIV, seenDV;

        memArr[32'h100] = 32'h00000013;

        // Reset state, with a fetch request already pending.
        #1;
        IReq = 1'b1;
        IAddr = 32'h100;
        rstChecks("rst0");
        tick();
        tick();

        // Lone fetch, issued on the first edge after release.
        RST = 1'b1;
        tick();
        chk("lone_IGnt", 32'(obsIGnt), 32'd1);
        chk("lone_MemRe", 32'(obsMemRe), 32'd1);
        chk("lone_MemAddr", obsMemAddr, 32'h100);
        IReq = 1'b0;
        tick();
        tick();
        tick();
        chk("lone_IValid", 32'(obsIValid), 32'd1);
        chk("lone_IRData", obsIRData, 32'h00000013);
        idle(2);

        // Simultaneous requests: data first, fetch issued alongside the data response.
        IReq = 1'b1; IAddr = 32'h104;
        DReq = 1'b1; DWe = 1'b0; DAddr = 32'h2000; DSize = 2'd2; DSign = 1'b0;
        tick();
        chk("simul_DGnt", 32'(obsDGnt), 32'd1);
        chk("simul_IGnt_T", 32'(obsIGnt), 32'd0);
        DReq = 1'b0;
        tick();
        tick();
        tick();
        chk("simul_IGnt_T3", 32'(obsIGnt), 32'd1);
        chk("simul_DValid_T3", 32'(obsDValid), 32'd1);
        chk("simul_DRData", obsDRData, memRd(32'h2000));
        IReq = 1'b0;
        idle(4);

        // Starvation: both held high continuously.
        IReq = 1'b1; IAddr = 32'h600;
        DReq = 1'b1; DWe = 1'b0; DAddr = 32'h2000;
        seq = "";
        for (int n = 0; n < 80 && seq.len() < 10; n++) begin
            tick();
            if (obsDGnt) seq = {seq, "D"};
            if (obsIGnt) seq = {seq, "I"};
        end
        testCnt++;
        assert (seq == "DDDDIDDDDI") else begin
            failCnt++;
            $error("FAIL starve_seq observed=%s expected=DDDDIDDDDI", seq);
        end
        idle(4);

        // Store: one write strobe, DRData untouched.
        DReq = 1'b1; DWe = 1'b1; DAddr = 32'h3000; DWData = 32'hDEADBEEF; DSize = 2'd2;
        tick();
        chk("store_MemWe", 32'(obsMemWe), 32'd1);
        chk("store_MemRe", 32'(obsMemRe), 32'd0);
        chk("store_MemAddr", obsMemAddr, 32'h3000);
        chk("store_MemWData", obsMemWData, 32'hDEADBEEF);
        chk("store_MemSize", 32'(obsMemSize), 32'd2);
        DReq = 1'b0; DWe = 1'b0;
        tick();
        chk("store_MemWe_T1", 32'(obsMemWe), 32'd0);
        tick();
        tick();
        chk("store_DValid", 32'(obsDValid), 32'd1);
        chk("store_DRData", obsDRData, memRd(32'h2000));
        idle(2);

        // Withdrawal: a one-cycle fetch request during a load's WAIT.
        DReq = 1'b1; DWe = 1'b0; DAddr = 32'h2004;
        tick();
        DReq = 1'b0;
        IReq = 1'b1; IAddr = 32'h500;
        seenIG = 0;
        seenIV = 0;
        tick();
        seenIG += int'(obsIGnt);
        IReq = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seenIG += int'(obsIGnt);
            seenIV += int'(obsIValid);
        end
        chk("withdraw_IGnt", 32'(seenIG), 32'd0);
        chk("withdraw_IValid", 32'(seenIV), 32'd0);

        // Reset mid-WAIT abandons the load.
        DReq = 1'b1; DWe = 1'b0; DAddr = 32'h2008;
        tick();
        DReq = 1'b0;
        IReq = 1'b1; IAddr = 32'h700;
        RST = 1'b0;
        #1;
        rstChecks("rstwait");
        modelEdge();
        cyc--;
        tick();
        tick();
        IReq = 1'b0;
        RST = 1'b1;
        seenDV = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seenDV += int'(obsDValid);
        end
        chk("rstwait_noDValid", 32'(seenDV), 32'd0);

        // Randomized traffic; requests held until granted, occasionally withdrawn.
        for (int n = 0; n < 400; n++) begin
            if (!IReq || obsIGnt) begin
                IReq  = ($urandom_range(0, 99) < 40);
                IAddr = $urandom;
            end else if ($urandom_range(0, 99) < 5) begin
                IReq = 1'b0;
            end
            if (!DReq || obsDGnt) begin
                DReq   = ($urandom_range(0, 99) < 50);
                DWe    = 1'($urandom_range(0, 1));
                DAddr  = 32'h4000 + 32'(4 * $urandom_range(0, 7));
                DWData = $urandom;
                DSize  = 2'($urandom_range(0, 2));
                DSign  = 1'($urandom_range(0, 1));
            end else if ($urandom_range(0, 99) < 5) begin
                DReq = 1'b0;
            end
            tick();
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule
